// File: rtl/vga_timing_pkg.sv
// Raster timing constants and helpers shared by vga_timing and the pixel generator.
package vga_timing_pkg;

    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;

    localparam logic [9:0] H_VIS_START  = 10'd48;
    localparam logic [9:0] H_VIS_END    = 10'd687;
    localparam logic [9:0] H_SYNC_START = 10'd704;
    localparam logic [9:0] V_VIS_START  = 10'd33;
    localparam logic [9:0] V_VIS_END    = 10'd512;
    localparam logic [9:0] V_SYNC_START = 10'd523;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
    } pos_t;

    function automatic logic in_window(input pos_t p);
        return (p.col >= H_VIS_START) && (p.col <= H_VIS_END) &&
               (p.row >= V_VIS_START) && (p.row <= V_VIS_END);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster generator: clk/4 pixel slots, raster counters with a two-slot look-ahead,
// and registered sync/blank/colour outputs.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] color_in,
    output logic       req,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic [9:0] next_col,
    output logic [9:0] next_row,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam pos_t       NXT_RST = '{row: 10'd0, col: 10'd2};

    function automatic pos_t advance(input pos_t p);
        pos_t n;
        n = p;
        if (p.col == H_LAST) begin
            n.col = '0;
            n.row = (p.row == V_LAST) ? '0 : p.row + 10'd1;
        end else begin
            n.col = p.col + 10'd1;
        end
        return n;
    endfunction

    logic [1:0] phase;
    pos_t       cur;
    pos_t       nxt;
    logic       vis;

    // Slot divider and raster counters; the look-ahead pair steps on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 2'd0;
            cur   <= '0;
            nxt   <= NXT_RST;
        end else begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                cur <= advance(cur);
                nxt <= advance(nxt);
            end
        end
    end

    assign vis = in_window(cur);

    // Output stage samples the position once per slot, one clk after it changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync                 <= 1'b1;
            vsync                 <= 1'b1;
            blank                 <= 1'b1;
            {vga_r, vga_g, vga_b} <= 8'd0;
        end else if (phase == 2'd0) begin
            hsync                 <= !(cur.col >= H_SYNC_START);
            vsync                 <= !(cur.row >= V_SYNC_START);
            blank                 <= !vis;
            {vga_r, vga_g, vga_b} <= vis ? color_in : 8'd0;
        end
    end

    assign req         = (phase == 2'd3);
    assign frame_start = !reset && (phase == 2'd0) && (cur == '0);
    assign col         = cur.col;
    assign row         = cur.row;
    assign next_col    = nxt.col;
    assign next_row    = nxt.row;

endmodule
